i2c_wr_scheduler: RTL and testbench
===================================

// Module: i2c_wr_scheduler
// PURPOSE
//  Queues byte-write requests (device addr, register addr, data) from the host side.
//  Issues them one at a time to the downstream byte-write I2C master through a start/done handshake.
//  Enforces the EEPROM write-cycle gap (tWR) between transactions.
//  Handles NACK, master timeout and request overflow with sticky error flags.
// PARAMETERS
//  DEPTH_LOG2    2     FIFO depth = 2**DEPTH_LOG2 entries (24-bit: cs_addr,rw_addr,input_data)
//  TWR_CYCLES    1000  clk cycles idle after each ACKed/NACKed transaction (100us @ 10MHz)
//  TIMEOUT_CYC   4096  max clk cycles waiting for m_done before abort
//  MAX_RETRY     3     reissues after NACK (used only with RETRY_NACK_EN)
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   async reset, active high
//  en_write    in   1   push request (1-cycle pulse per request)
//  cs_addr     in   8   {7-bit device addr, R/W}; R/W must be 0
//  rw_addr     in   8   register/memory address
//  input_data  in   8   write data
//  req_full    out  1   FIFO full (registered from count)
//  busy        out  1   1 when state!=IDLE or FIFO non-empty
//  m_start     out  1   1-cycle start pulse to master
//  m_dev       out  8   device byte, stable from m_start until done/abort
//  m_addr      out  8   address byte, same stability rule
//  m_data      out  8   data byte, same stability rule
//  m_done      in   1   1-cycle pulse: master finished transaction
//  m_nack      in   1   qualified by m_done: 1 = slave NACKed
//  err         out  3   sticky: [0] NACK final, [1] overflow/illegal req, [2] timeout
//  err_clr     in   1   clears err (set in same cycle wins)
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE, counters 0; reset mid-transaction drops it.
//  Push: accepted if en_write & !req_full & cs_addr[0]==0.
//   - full or cs_addr[0]==1: request dropped, err[1]<=1.
//   - Full is judged on count before the edge; a same-cycle pop does not free space.
//   - Push+pop in the same cycle (not full): count unchanged.
//  FSM IDLE->LOAD->ISSUE->WAIT->GAP->IDLE:
//   IDLE : FIFO non-empty -> LOAD.
//   LOAD : pop head into m_dev/m_addr/m_data, retry_cnt<=0 -> ISSUE.
//   ISSUE: m_start=1 for exactly one cycle, watchdog<=0 -> WAIT.
//   WAIT : m_done&!m_nack -> GAP.
//          m_done&m_nack -> see macro.
//          watchdog==TIMEOUT_CYC-1 -> err[2]<=1, -> IDLE (entry discarded).
//          m_done in the same cycle as timeout: m_done wins.
//   GAP  : countdown TWR_CYCLES cycles; at 0 -> ISSUE if retry pending, else IDLE.
//  Latency: push at edge N into empty FIFO while IDLE -> m_start high in cycle N+2.
//  m_done outside WAIT is ignored. m_start is never reasserted before GAP expires.
//  Counters are sized by $clog2(param+1); no wrap in normal operation.
// CONFIGURATION
//  RETRY_NACK_EN defined:
//   - NACK with retry_cnt<MAX_RETRY: retry_cnt++, -> GAP then ISSUE with the same bytes.
//   - Otherwise err[0]<=1, -> GAP then IDLE.
//  RETRY_NACK_EN undefined:
//   - any NACK sets err[0], -> GAP then IDLE; MAX_RETRY is unused.
// TESTING
//  1 Push (0x0E,0x48,0x55),(0x0E,0x49,0xAA),(0x0E,0x4A,0xCC) back-to-back; master ACKs 20 cyc after start
//    -> 3 m_start pulses in order, bytes match, start spacing = 1+20+TWR_CYCLES+1 cycles, err=0.
//  2 Push 5 requests in 5 consecutive cycles, DEPTH_LOG2=2, master stalled
//    -> first popped, next 4 queued, none dropped; 6th push while full -> err[1]=1, req_full=1.
//  3 Push with cs_addr=0x0F -> not queued, no m_start, err[1]=1; err_clr -> err=0.
//  4 Master always NACKs: with RETRY_NACK_EN -> 4 m_start with identical bytes, then err[0]=1;
//    without the macro -> 1 m_start, then err[0]=1.
//  5 Master never returns m_done -> err[2]=1 at TIMEOUT_CYC cycles after start, next entry issued.
//  6 Assert rst during WAIT -> all outputs 0 immediately, FIFO empty, no further m_start.

Source files
------------

// File: rtl/i2c_wr_if.sv
// i2c_wr_if
//  Bundles the host request port and the downstream byte-write I2C master
//  handshake of the write scheduler.
//  master : scheduler side (accepts host requests, drives m_start/m_dev/m_addr/m_data)
//  slave  : environment side (host + byte-write I2C master)
//  Signals:
//   en_write, cs_addr[7:0], rw_addr[7:0], input_data[7:0]  host push request
//   req_full, busy, err[2:0]                               host status
//   err_clr                                                host clears sticky errors
//   m_start, m_dev[7:0], m_addr[7:0], m_data[7:0]          transaction to I2C master
//   m_done, m_nack                                         completion from I2C master
interface i2c_wr_if;
   logic       en_write;
   logic [7:0] cs_addr;
   logic [7:0] rw_addr;
   logic [7:0] input_data;
   logic       req_full;
   logic       busy;
   logic       m_start;
   logic [7:0] m_dev;
   logic [7:0] m_addr;
   logic [7:0] m_data;
   logic       m_done;
   logic       m_nack;
   logic [2:0] err;
   logic       err_clr;

   modport master (
      input  en_write, cs_addr, rw_addr, input_data, m_done, m_nack, err_clr,
      output req_full, busy, m_start, m_dev, m_addr, m_data, err
   );

   modport slave (
      output en_write, cs_addr, rw_addr, input_data, m_done, m_nack, err_clr,
      input  req_full, busy, m_start, m_dev, m_addr, m_data, err
   );
endinterface

// File: rtl/i2c_wr_scheduler.sv
// i2c_wr_scheduler
//  Queues EEPROM byte-write requests and issues them one at a time to a
//  byte-write I2C master, holding off the next start for the tWR write cycle.
//  NACK, master timeout and dropped/illegal requests raise sticky err bits.
//  Ports:
//   clk  clock, rising edge
//   rst  asynchronous reset, active high
//   bus  i2c_wr_if.master (host request/status + master start/done handshake)
//  Optional build macro RETRY_NACK_EN: reissue a NACKed transaction up to
//  MAX_RETRY times before flagging err[0].
//
//  state | meaning
//  IDLE  | waiting for a queued request
//  LOAD  | pop FIFO head into the master byte registers
//  ISSUE | one-cycle m_start pulse, watchdog cleared
//  WAIT  | waiting for m_done or watchdog expiry
//  GAP   | tWR write-cycle gap before next start
module i2c_wr_scheduler #(
   parameter int DEPTH_LOG2  = 2,
   parameter int TWR_CYCLES  = 1000,
   parameter int TIMEOUT_CYC = 4096,
   parameter int MAX_RETRY   = 3
) (
   input logic       clk,
   input logic       rst,
   i2c_wr_if.master  bus
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int WW    = $clog2(TIMEOUT_CYC + 1);
   localparam int GW    = $clog2(TWR_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, GAP} state_t;

   state_t state, state_nxt;

   logic [23:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0]         count, count_nxt;
   logic                  req_full;
   logic                  push_ok, push_bad, pop;

   logic [7:0]            m_dev, m_addr, m_data;
   logic [WW-1:0]         watchdog;
   logic [GW-1:0]         gap_cnt;
   logic [2:0]            err, err_set;
   logic                  start_c, nack_err, timeout_err;

`ifdef RETRY_NACK_EN
   localparam int RW = $clog2(MAX_RETRY + 1);
   logic [RW-1:0] retry_cnt;
   logic          retry_pend;
   logic          retry_inc;
`else
   // Retries do not exist in this build; MAX_RETRY is intentionally inert.
   localparam int unused_max_retry = MAX_RETRY;
`endif

   // Full is judged on the registered count, so a same-cycle pop never makes room.
   assign push_ok  = bus.en_write & ~req_full & ~bus.cs_addr[0];
   assign push_bad = bus.en_write & (req_full | bus.cs_addr[0]);

   always_comb begin
      count_nxt = count;
      case ({push_ok, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {bus.cs_addr, bus.rw_addr, bus.input_data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         req_full <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
         if (pop)     rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
         count    <= count_nxt;
         req_full <= (count_nxt == CW'(DEPTH));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      pop         = 1'b0;
      start_c     = 1'b0;
      nack_err    = 1'b0;
      timeout_err = 1'b0;
`ifdef RETRY_NACK_EN
      retry_inc   = 1'b0;
`endif
      case (state)
         IDLE:  if (count != '0) state_nxt = LOAD;
         LOAD: begin
            pop       = 1'b1;
            state_nxt = ISSUE;
         end
         ISSUE: begin
            start_c   = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            // A completion in the same cycle as watchdog expiry is honoured.
            if (bus.m_done) begin
               state_nxt = GAP;
               if (bus.m_nack) begin
`ifdef RETRY_NACK_EN
                  if (retry_cnt < RW'(MAX_RETRY)) retry_inc = 1'b1;
                  else                            nack_err  = 1'b1;
`else
                  nack_err = 1'b1;
`endif
               end
            end else if (watchdog == WW'(TIMEOUT_CYC - 1)) begin
               timeout_err = 1'b1;
               state_nxt   = IDLE;
            end
         end
         GAP: begin
            if (gap_cnt == '0) begin
`ifdef RETRY_NACK_EN
               state_nxt = retry_pend ? ISSUE : IDLE;
`else
               state_nxt = IDLE;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_dev    <= '0;
         m_addr   <= '0;
         m_data   <= '0;
         watchdog <= '0;
         gap_cnt  <= '0;
`ifdef RETRY_NACK_EN
         retry_cnt  <= '0;
         retry_pend <= 1'b0;
`endif
      end else begin
         if (state == LOAD) {m_dev, m_addr, m_data} <= mem[rd_ptr];

         if (state == ISSUE)     watchdog <= '0;
         else if (state == WAIT) watchdog <= watchdog + WW'(1);

         // Loaded with TWR_CYCLES-1 so GAP spans exactly TWR_CYCLES cycles.
         if (state == WAIT && state_nxt == GAP)  gap_cnt <= GW'(TWR_CYCLES - 1);
         else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);

`ifdef RETRY_NACK_EN
         if (state == LOAD) begin
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
         end else if (retry_inc) begin
            retry_cnt  <= retry_cnt + RW'(1);
            retry_pend <= 1'b1;
         end else if (state == GAP && state_nxt == ISSUE) begin
            retry_pend <= 1'b0;
         end
`endif
      end
   end

   assign err_set = {timeout_err, push_bad, nack_err};

   // A new error in the same cycle as err_clr survives the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err <= '0;
      else     err <= (err & ~{3{bus.err_clr}}) | err_set;
   end

   assign bus.req_full = req_full;
   assign bus.busy     = (state != IDLE) || (count != '0);
   assign bus.m_start  = start_c;
   assign bus.m_dev    = m_dev;
   assign bus.m_addr   = m_addr;
   assign bus.m_data   = m_data;
   assign bus.err      = err;

endmodule

// File: tb/tb_i2c_wr_scheduler.sv
module tb_i2c_wr_scheduler;

   localparam int TWR   = 10;
   localparam int TOUT  = 64;
   localparam int DONE_LAT = 19;   // m_done lands in the 20th cycle of the transaction
`ifdef RETRY_NACK_EN
   localparam int EXP_NACK_STARTS = 4;
`else
   localparam int EXP_NACK_STARTS = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   // master model modes: 0 ack, 1 nack, 2 never answers
   int   mst_mode = 0;
   int   done_at  = -1;

   int   st_cyc[$];
   logic [7:0] st_dev[$], st_addr[$], st_data[$];
   int   err2_q[$];
   logic prev_err2 = 1'b0;

   i2c_wr_if bus();

   i2c_wr_scheduler #(
      .DEPTH_LOG2 (2),
      .TWR_CYCLES (TWR),
      .TIMEOUT_CYC(TOUT),
      .MAX_RETRY  (3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.m_start) begin
         st_cyc.push_back(cyc);
         st_dev.push_back(bus.m_dev);
         st_addr.push_back(bus.m_addr);
         st_data.push_back(bus.m_data);
      end
      if (bus.err[2] && !prev_err2) err2_q.push_back(cyc);
      prev_err2 = bus.err[2];
   end

   always @(negedge clk) begin
      if (bus.m_start && mst_mode != 2) done_at = cyc + DONE_LAT;
      bus.m_done = (cyc == done_at) && !rst;
      bus.m_nack = (cyc == done_at) && !rst && (mst_mode == 1);
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [7:0] cs, input logic [7:0] ra, input logic [7:0] d);
      bus.en_write   = 1'b1;
      bus.cs_addr    = cs;
      bus.rw_addr    = ra;
      bus.input_data = d;
      tick(1);
      bus.en_write   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic wait_starts(input int target, input int budget, input string tag);
      for (int i = 0; i < budget && st_cyc.size() < target; i++) tick(1);
      check_val(tag, st_cyc.size(), target);
   endtask

   initial begin
      int base, n0, s1;
      logic [7:0] exp_a [3];
      logic [7:0] exp_d [3];
      exp_a[0] = 8'h48; exp_a[1] = 8'h49; exp_a[2] = 8'h4A;
      exp_d[0] = 8'h55; exp_d[1] = 8'hAA; exp_d[2] = 8'hCC;

      bus.en_write = 0; bus.cs_addr = 0; bus.rw_addr = 0; bus.input_data = 0; bus.err_clr = 0;
      tick(2);
      check_val("rst_outputs",
                {bus.m_start, bus.busy, bus.req_full, bus.err, bus.m_dev, bus.m_addr, bus.m_data}, 0);
      rst = 1'b0;
      tick(1);

      // back-to-back ACKed writes: order, bytes, latency, start spacing
      mst_mode = 0;
      base = st_cyc.size();
      n0 = cyc + 1;
      push(8'h0E, 8'h48, 8'h55);
      push(8'h0E, 8'h49, 8'hAA);
      push(8'h0E, 8'h4A, 8'hCC);
      wait_starts(base + 3, 300, "ack_start_count");
      if (st_cyc.size() >= base + 3) begin
         check_val("ack_latency", st_cyc[base] - n0, 2);
         for (int i = 0; i < 3; i++) begin
            check_val($sformatf("ack_dev%0d", i),  st_dev[base+i],  8'h0E);
            check_val($sformatf("ack_addr%0d", i), st_addr[base+i], exp_a[i]);
            check_val($sformatf("ack_data%0d", i), st_data[base+i], exp_d[i]);
         end
         check_val("ack_space01", st_cyc[base+1] - st_cyc[base], 1 + 20 + TWR + 1);
         check_val("ack_space12", st_cyc[base+2] - st_cyc[base+1], 1 + 20 + TWR + 1);
      end
      tick(40);
      check_val("ack_err", bus.err, 3'b000);
      check_val("ack_busy_end", bus.busy, 1'b0);
      check_val("ack_no_extra", st_cyc.size(), base + 3);

      // fill FIFO with stalled master, then overflow
      do_reset();
      mst_mode = 2;
      base = st_cyc.size();
      for (int i = 0; i < 5; i++) push(8'h0E, 8'(8'h60 + i), 8'(8'h10 + i));
      check_val("fill_full", bus.req_full, 1'b1);
      check_val("fill_err", bus.err, 3'b000);
      check_val("fill_one_start", st_cyc.size(), base + 1);
      push(8'h0E, 8'h66, 8'h16);
      check_val("ovf_err1", bus.err[1], 1'b1);
      check_val("ovf_full", bus.req_full, 1'b1);
      wait_starts(base + 5, 600, "fill_drain_count");
      for (int i = 0; i < 5; i++)
         if (st_cyc.size() > base + i)
            check_val($sformatf("fill_addr%0d", i), st_addr[base+i], 8'(8'h60 + i));
      tick(TOUT + 10);
      check_val("ovf_dropped", st_cyc.size(), base + 5);

      // illegal R/W bit, then clear; set beats clear in the same cycle
      do_reset();
      mst_mode = 0;
      base = st_cyc.size();
      push(8'h0F, 8'h11, 8'h22);
      tick(6);
      check_val("ill_no_start", st_cyc.size(), base);
      check_val("ill_err", bus.err, 3'b010);
      check_val("ill_busy", bus.busy, 1'b0);
      bus.err_clr = 1'b1;
      tick(1);
      bus.err_clr = 1'b0;
      check_val("clr_err", bus.err, 3'b000);
      bus.err_clr = 1'b1;
      push(8'h0F, 8'h11, 8'h22);
      bus.err_clr = 1'b0;
      check_val("clr_set_wins", bus.err, 3'b010);

      // master always NACKs
      do_reset();
      mst_mode = 1;
      base = st_cyc.size();
      push(8'h0E, 8'h20, 8'h77);
      tick(250);
      check_val("nack_starts", st_cyc.size(), base + EXP_NACK_STARTS);
      for (int i = 0; i < EXP_NACK_STARTS; i++)
         if (st_cyc.size() > base + i)
            check_val($sformatf("nack_bytes%0d", i),
                      {st_dev[base+i], st_addr[base+i], st_data[base+i]}, 24'h0E2077);
`ifdef RETRY_NACK_EN
      if (st_cyc.size() > base + 1)
         check_val("nack_retry_space", st_cyc[base+1] - st_cyc[base], 1 + DONE_LAT + TWR);
`endif
      check_val("nack_err", bus.err, 3'b001);

      // master never answers: timeout, next entry issued
      do_reset();
      mst_mode = 2;
      base = st_cyc.size();
      n0 = err2_q.size();
      push(8'h0E, 8'h30, 8'h01);
      push(8'h0E, 8'h31, 8'h02);
      push(8'h0E, 8'h32, 8'h03);
      wait_starts(base + 2, 300, "tout_start_count");
      check_val("tout_err2_seen", err2_q.size(), n0 + 1);
      if (st_cyc.size() >= base + 2 && err2_q.size() > n0) begin
         s1 = st_cyc[base];
         check_val("tout_err2_time", err2_q[n0] - s1, TOUT + 1);
         check_val("tout_next_space", st_cyc[base+1] - s1, TOUT + 3);
         check_val("tout_next_addr", st_addr[base+1], 8'h31);
      end
      check_val("tout_err", bus.err, 3'b100);

      // reset while WAITing with a queued entry
      tick(3);
      #2 rst = 1'b1;
      #1;
      check_val("rst_wait_start", bus.m_start, 1'b0);
      check_val("rst_wait_bytes", {bus.m_dev, bus.m_addr, bus.m_data}, 24'h0);
      check_val("rst_wait_stat", {bus.err, bus.busy, bus.req_full}, 5'b0);
      tick(1);
      rst = 1'b0;
      base = st_cyc.size();
      tick(150);
      check_val("rst_no_start", st_cyc.size(), base);
      check_val("rst_fifo_empty", bus.busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "bench time limit");
   end

endmodule
